line_refill_axi_master: RTL and testbench

- AXI4 read-only master that sits directly upstream of the on-chip ROM/DRAM slave wrappers, reached through the interconnect.
- Accepts one cache-line refill request from the instruction/data cache and issues a single INCR read burst of BEATS x 32-bit words.
- Assembles the returned beats into a line buffer and hands the full line back to the cache with a valid/ready handshake.
- One transaction outstanding at a time.

---
 rtl/line_refill_axi_master.sv | 128 ++++++++++++
 tb/tb_line_refill_axi_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_refill_axi_master.sv
// Cache-line refill AXI4 read master: one request in, one INCR burst out,
// the assembled line back to the cache. Single transaction outstanding.
// Optional: define REFILL_RESP_CHECK_EN to fold non-OKAY RRESP into line_err.
module line_refill_axi_master #(
    parameter int unsigned BEATS = 4,
    parameter int unsigned AXI_ID_BITS = 4,
    parameter int unsigned AXI_LEN_BITS = 8,
    parameter int unsigned AXI_SIZE_BITS = 3,
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0,
    parameter int unsigned LINE_W = 32 * BEATS
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     line_valid,
    input  logic                     line_ready,
    output logic [LINE_W-1:0]        line_data,
    output logic                     line_err,
    output logic [AXI_ID_BITS-1:0]   ARID_M,
    output logic [31:0]              ARADDR_M,
    output logic [AXI_LEN_BITS-1:0]  ARLEN_M,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE_M,
    output logic [1:0]               ARBURST_M,
    output logic                     ARVALID_M,
    input  logic                     ARREADY_M,
    input  logic [AXI_ID_BITS-1:0]   RID_M,
    input  logic [31:0]              RDATA_M,
    input  logic [1:0]               RRESP_M,
    input  logic                     RLAST_M,
    input  logic                     RVALID_M,
    output logic                     RREADY_M
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(4 * BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAr, StRd, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [LINE_W-1:0]  line_q, line_d;

    // RID is not checked and the in-line offset bits are discarded by alignment.
    logic unused_ok;
    assign unused_ok = ^{RID_M, RRESP_M, req_addr[OFF_W-1:0]};

    // State, address, counter, error flag and line buffer registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            line_q  <= line_d;
        end
    end

    // Next-state: request latch, AR handshake, beat capture with framing checks.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        line_d  = line_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (ARREADY_M) state_d = StRd;
            end
            StRd: begin
                if (RVALID_M) begin
                    line_d[32*int'(cnt_q) +: 32] = RDATA_M;
                    // Saturate so an overlong burst can never wrap onto word 0.
                    if (cnt_q != LAST_CNT) cnt_d = cnt_q + 1'b1;
`ifdef REFILL_RESP_CHECK_EN
                    if (RRESP_M != 2'b00) err_d = 1'b1;
`endif
                    if (RLAST_M) begin
                        state_d = StDone;
                        if (cnt_q != LAST_CNT) err_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        // Slave failed to flag the last beat: stop listening.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                if (line_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so reset drops them immediately.
    always_comb begin
        req_ready  = (state_q == StIdle);
        ARVALID_M  = (state_q == StAr);
        RREADY_M   = (state_q == StRd);
        line_valid = (state_q == StDone);
        line_data  = line_q;
        line_err   = err_q;
        ARADDR_M   = addr_q;
        ARID_M     = MASTER_ID;
        ARLEN_M    = AXI_LEN_BITS'(BEATS - 1);
        ARSIZE_M   = AXI_SIZE_BITS'(2);
        ARBURST_M  = 2'b01;
    end

endmodule

// File: tb/tb_line_refill_axi_master.sv
// Scoreboard bench for line_refill_axi_master (BEATS=4).
module tb_line_refill_axi_master;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
    } line_t;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         line_valid;
    logic         line_ready = 1'b0;
    logic [127:0] line_data;
    logic         line_err;
    logic [3:0]   ARID_M;
    logic [31:0]  ARADDR_M;
    logic [7:0]   ARLEN_M;
    logic [2:0]   ARSIZE_M;
    logic [1:0]   ARBURST_M;
    logic         ARVALID_M;
    logic         ARREADY_M = 1'b0;
    logic [3:0]   RID_M = '0;
    logic [31:0]  RDATA_M = '0;
    logic [1:0]   RRESP_M = '0;
    logic         RLAST_M = 1'b0;
    logic         RVALID_M = 1'b0;
    logic         RREADY_M;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ar_q[$];
    line_t       line_q[$];
    logic        resp_err_exp;

    line_refill_axi_master #(.BEATS(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_err(line_err),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
        .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
        .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M),
        .RLAST_M(RLAST_M), .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every AR and line handshake against the scoreboard.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (ARVALID_M && ARREADY_M) begin
                if (ar_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ar_unexpected: got addr %h expected none", ARADDR_M);
                end else begin
                    check("ar_addr", ARADDR_M, ar_q.pop_front());
                    check("ar_len", ARLEN_M, 3);
                    check("ar_size", ARSIZE_M, 3'b010);
                    check("ar_burst", ARBURST_M, 2'b01);
                    check("ar_id", ARID_M, 0);
                end
            end
            if (line_valid && line_ready) begin
                if (line_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL line_unexpected: got %h expected none", line_data);
                end else begin
                    line_t e;
                    e = line_q.pop_front();
                    check("line_data", line_data, e.data);
                    check("line_err", line_err, e.err);
                end
            end
        end
    end

    // Issue a request; the DUT must be idle and accept it in one cycle.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] exp_ar);
        ar_q.push_back(exp_ar);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge ACLK);
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge ACLK); #1;
        req_valid = 1'b0;
    endtask

    // Hold ARREADY low for stall cycles, checking AR stability, then accept.
    task automatic do_ar(input int stall, input logic [31:0] exp_ar);
        ARREADY_M = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge ACLK);
            check("ar_stall_valid", ARVALID_M, 1'b1);
            check("ar_stall_addr", ARADDR_M, exp_ar);
            check("ar_stall_req_ready", req_ready, 1'b0);
            @(posedge ACLK); #1;
        end
        ARREADY_M = 1'b1;
        @(negedge ACLK);
        check("ar_valid", ARVALID_M, 1'b1);
        @(posedge ACLK); #1;
        ARREADY_M = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                           input bit gap);
        RVALID_M = 1'b1;
        RDATA_M  = d;
        RLAST_M  = last;
        RRESP_M  = resp;
        @(negedge ACLK);
        check("rready", RREADY_M, 1'b1);
        @(posedge ACLK); #1;
        RVALID_M = 1'b0;
        RLAST_M  = 1'b0;
        RRESP_M  = 2'b00;
        if (gap) begin
            @(posedge ACLK); #1;
        end
    endtask

    // Line must be up the cycle after the last beat; consume after hold cycles.
    task automatic do_consume(input int hold);
        @(negedge ACLK);
        check("line_valid_lat", line_valid, 1'b1);
        check("rready_done", RREADY_M, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check("line_valid_hold", line_valid, 1'b1);
        end
        @(posedge ACLK); #1;
        line_ready = 1'b1;
        @(negedge ACLK);
        check("req_ready_consume", req_ready, 1'b0);
        @(posedge ACLK); #1;
        line_ready = 1'b0;
        @(negedge ACLK);
        check("req_ready_after", req_ready, 1'b1);
        check("line_valid_after", line_valid, 1'b0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REFILL_RESP_CHECK_EN
        resp_err_exp = 1'b1;
`else
        resp_err_exp = 1'b0;
`endif
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_arvalid", ARVALID_M, 1'b0);
        check("rst_rready", RREADY_M, 1'b0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_line_err", line_err, 1'b0);
        check("rst_line_data", line_data, 128'h0);
        check("rst_araddr", ARADDR_M, 32'h0);
        check("rst_arlen", ARLEN_M, 3);
        check("rst_arsize", ARSIZE_M, 2);
        check("rst_arburst", ARBURST_M, 1);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Basic refill, zero stalls.
        line_q.push_back('{128'h000000A3_000000A2_000000A1_000000A0, 1'b0});
        do_req(32'h0000_1234, 32'h0000_1230);
        do_ar(0, 32'h0000_1230);
        do_beat(32'hA0, 0, 2'b00, 0);
        do_beat(32'hA1, 0, 2'b00, 0);
        do_beat(32'hA2, 0, 2'b00, 0);
        do_beat(32'hA3, 1, 2'b00, 0);
        do_consume(0);

        // AR stalled 5 cycles, RVALID toggling, line held 3 extra cycles.
        line_q.push_back('{128'h000000B3_000000B2_000000B1_000000B0, 1'b0});
        do_req(32'h0000_2FFC, 32'h0000_2FF0);
        do_ar(5, 32'h0000_2FF0);
        do_beat(32'hB0, 0, 2'b00, 1);
        do_beat(32'hB1, 0, 2'b00, 1);
        do_beat(32'hB2, 0, 2'b00, 1);
        do_beat(32'hB3, 1, 2'b00, 0);
        do_consume(3);

        // Early RLAST on beat 1: upper words keep the previous line.
        line_q.push_back('{128'h000000B3_000000B2_000000C1_000000C0, 1'b1});
        do_req(32'h0000_0044, 32'h0000_0040);
        do_ar(0, 32'h0000_0040);
        do_beat(32'hC0, 0, 2'b00, 0);
        do_beat(32'hC1, 1, 2'b00, 0);
        do_consume(1);

        // Missing RLAST; a stray beat in DONE must not be taken.
        line_q.push_back('{128'h000000D3_000000D2_000000D1_000000D0, 1'b1});
        do_req(32'h0000_0100, 32'h0000_0100);
        do_ar(0, 32'h0000_0100);
        do_beat(32'hD0, 0, 2'b00, 0);
        do_beat(32'hD1, 0, 2'b00, 0);
        do_beat(32'hD2, 0, 2'b00, 0);
        do_beat(32'hD3, 0, 2'b00, 0);
        RVALID_M = 1'b1;
        RDATA_M  = 32'hDEAD_BEEF;
        RLAST_M  = 1'b1;
        do_consume(1);
        RVALID_M = 1'b0;
        RLAST_M  = 1'b0;

        // SLVERR on beat 2: flagged only with response checking built in.
        line_q.push_back('{128'h000000E3_000000E2_000000E1_000000E0, resp_err_exp});
        do_req(32'h0000_0208, 32'h0000_0200);
        do_ar(0, 32'h0000_0200);
        do_beat(32'hE0, 0, 2'b00, 0);
        do_beat(32'hE1, 0, 2'b00, 0);
        do_beat(32'hE2, 0, 2'b10, 0);
        do_beat(32'hE3, 1, 2'b00, 0);
        do_consume(0);

        // Reset in the middle of the data phase.
        do_req(32'h0000_0300, 32'h0000_0300);
        do_ar(0, 32'h0000_0300);
        do_beat(32'hF0, 0, 2'b00, 0);
        do_beat(32'hF1, 0, 2'b00, 0);
        ARESETn = 1'b0;
        #1;
        check("midrst_arvalid", ARVALID_M, 1'b0);
        check("midrst_rready", RREADY_M, 1'b0);
        check("midrst_line_valid", line_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_line_data", line_data, 128'h0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("postrst_line_valid", line_valid, 1'b0);

        // Fresh request completes normally after the reset.
        line_q.push_back('{128'h00000013_00000012_00000011_00000010, 1'b0});
        do_req(32'h0000_0FF8, 32'h0000_0FF0);
        do_ar(0, 32'h0000_0FF0);
        do_beat(32'h10, 0, 2'b00, 0);
        do_beat(32'h11, 0, 2'b00, 0);
        do_beat(32'h12, 0, 2'b00, 0);
        do_beat(32'h13, 1, 2'b00, 0);
        do_consume(0);

        repeat (2) @(posedge ACLK);
        check("ar_q_drained", ar_q.size(), 0);
        check("line_q_drained", line_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
